// File: rtl/noc_local_sink_if.sv
// noc_local_sink_if: handshake bundle between router local ports, the sink and its consumer.
//   valid_i/data_i/ready_o/credit_upd : per-channel ingress from router local outputs
//   valid_o/data_o/ch_o/ready_i       : merged egress stream to the consumer
//   slave  : sink side (noc_local_sink)
//   master : router/consumer side (testbench or surrounding fabric)
interface noc_local_sink_if #(
  parameter int unsigned DW     = 16,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CW     = 2
);
  logic [NUM_CH-1:0]    valid_i;
  logic [NUM_CH*DW-1:0] data_i;
  logic [NUM_CH-1:0]    ready_o;
  logic [NUM_CH-1:0]    credit_upd;
  logic                 valid_o;
  logic [DW-1:0]        data_o;
  logic [CW-1:0]        ch_o;
  logic                 ready_i;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, credit_upd, valid_o, data_o, ch_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, credit_upd, valid_o, data_o, ch_o
  );
endinterface

// File: rtl/noc_local_sink.sv
// noc_local_sink: multi-channel receive endpoint for router local output ports.
// Buffers flits per channel, merges channels round-robin (per flit or per packet),
// returns one credit pulse per consumed flit, counts accepted flits, flags overflow.
//   clk, rst   : single clock, synchronous active-high reset
//   bus        : noc_local_sink_if.slave (ingress handshakes, merged egress stream)
//   flit_cnt_o : per-channel accepted-flit counters, channel c at [c*CNT_W +: CNT_W]
//   err_ovf_o  : per-channel sticky flag, valid_i seen while that FIFO was full
module noc_local_sink #(
  parameter int unsigned DW       = 16,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PKT_MODE = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  noc_local_sink_if.slave           bus,
  output logic [NUM_CH*CNT_W-1:0]   flit_cnt_o,
  output logic [NUM_CH-1:0]         err_ovf_o
);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW = $clog2(DEPTH);

  // S_ARB: free search; S_HOLD: stalled grant pinned; S_LOCK: packet grant pinned
  typedef enum logic [1:0] {S_ARB, S_HOLD, S_LOCK} state_t;
  state_t r_state, w_state_nxt;

  logic [DW-1:0]    r_mem [NUM_CH][DEPTH];
  logic [AW:0]      r_wp  [NUM_CH];
  logic [AW:0]      r_rp  [NUM_CH];
  logic [CNT_W-1:0] r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_ovf, r_credit;
  logic [NUM_CH-1:0] w_full, w_empty, w_push, w_pop;
  logic [DW-1:0]    w_head [NUM_CH];
  logic [CW-1:0]    r_p, w_p_nxt, r_gnt, w_gnt_nxt, w_g, w_srch_g, w_g_inc, r_last_ch;
  logic [DW-1:0]    r_last_data;
  logic             w_srch_hit, w_valid, w_fire;

  // FIFO status; pointers carry an extra wrap bit to tell full from empty
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_empty[c] = (r_wp[c] == r_rp[c]);
      w_full[c]  = (r_wp[c][AW] != r_rp[c][AW]) && (r_wp[c][AW-1:0] == r_rp[c][AW-1:0]);
      w_head[c]  = r_mem[c][r_rp[c][AW-1:0]];
      w_push[c]  = bus.valid_i[c] && !w_full[c];
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      w_pop[c] = w_fire && (w_g == CW'(c));
  end

  // Round-robin search starting at r_p, wrapping modulo NUM_CH
  always_comb begin
    int unsigned idx;
    idx        = 0;
    w_srch_hit = 1'b0;
    w_srch_g   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(r_p) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_srch_hit && !w_empty[CW'(idx)]) begin
        w_srch_hit = 1'b1;
        w_srch_g   = CW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_p_nxt     = r_p;
    w_g         = r_gnt;
    w_valid     = !w_empty[r_gnt];
    if (r_state == S_ARB) begin
      w_g     = w_srch_g;
      w_valid = w_srch_hit;
    end
    w_fire  = w_valid && bus.ready_i;
    w_g_inc = (w_g == CW'(NUM_CH - 1)) ? '0 : w_g + 1'b1;
    if (w_valid) w_gnt_nxt = w_g;
    if (w_fire) begin
      if (PKT_MODE != 0 && !w_head[w_g][DW-1]) begin
        w_state_nxt = S_LOCK;
      end else begin
        w_state_nxt = S_ARB;
        w_p_nxt     = w_g_inc;
      end
    end else if (w_valid && r_state == S_ARB) begin
      w_state_nxt = S_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ARB;
      r_p     <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit    <= '0;
      r_last_data <= '0;
      r_last_ch   <= '0;
    end else begin
      r_credit <= '0;
      if (w_fire) r_credit[w_g] <= 1'b1;
      if (w_valid) begin
        r_last_data <= w_head[w_g];
        r_last_ch   <= w_g;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
        r_ovf[c] <= 1'b0;
      end else begin
        if (w_push[c]) begin
          r_wp[c]  <= r_wp[c] + 1'b1;
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
        if (w_pop[c]) r_rp[c] <= r_rp[c] + 1'b1;
        if (bus.valid_i[c] && w_full[c]) r_ovf[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (w_push[c]) r_mem[c][r_wp[c][AW-1:0]] <= bus.data_i[c*DW +: DW];
  end

  always_comb begin
    flit_cnt_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      flit_cnt_o[c*CNT_W +: CNT_W] = r_cnt[c];
  end

  assign err_ovf_o      = r_ovf;
  assign bus.ready_o    = ~w_full;
  assign bus.credit_upd = r_credit;
  assign bus.valid_o    = w_valid;
  assign bus.data_o     = w_valid ? w_head[w_g] : r_last_data;
  assign bus.ch_o       = w_valid ? w_g : r_last_ch;
endmodule
